// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin owner of one synchronous data-memory port shared by core_count cores.
// Latency: request sampled in IDLE, ack two edges later, next grant four edges after the first.
// Backpressure: a core holds req until ack; losing requesters wait in place, nothing is dropped.
module dm_arbiter #(
  parameter int core_count = 2,
  parameter int addr_width = 12,
  parameter int reg_width  = 12
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [core_count-1:0]            req,
  input  logic [core_count-1:0]            we,
  input  logic [addr_width*core_count-1:0] addr,
  input  logic [reg_width*core_count-1:0]  wdata,
  output logic [reg_width*core_count-1:0]  rdata,
  output logic [core_count-1:0]            ack,
  output logic [core_count-1:0]            grant,
  output logic                             busy,
  output logic [addr_width-1:0]            mem_addr,
  output logic [reg_width-1:0]             mem_wdata,
  output logic                             mem_we,
  input  logic [reg_width-1:0]             mem_rdata
);

  localparam int idx_w = (core_count > 1) ? $clog2(core_count) : 1;

  localparam logic [1:0] st_idle   = 2'd0;
  localparam logic [1:0] st_access = 2'd1;
  localparam logic [1:0] st_resp   = 2'd2;
  localparam logic [1:0] st_done   = 2'd3;

  logic [1:0]            state;
  logic [idx_w-1:0]      last;
  logic [idx_w-1:0]      cur;
  logic                  cur_we;
  logic [idx_w-1:0]      win;
  logic [idx_w-1:0]      cand;
  logic                  win_vld;
  logic [core_count-1:0] win_oh;

  // Search starts one past the previous owner so every requester is reached within core_count grants.
  always_comb begin
    win     = '0;
    cand    = '0;
    win_vld = 1'b0;
    for (int i = 1; i <= core_count; i++) begin
      cand = idx_w'((int'(last) + i) % core_count);
      if (!win_vld && req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  assign busy = (state != st_idle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= st_idle;
      last      <= idx_w'(core_count - 1);
      cur       <= '0;
      cur_we    <= 1'b0;
      grant     <= '0;
      ack       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        st_idle: begin
          if (win_vld) begin
            grant     <= win_oh;
            cur       <= win;
            cur_we    <= we[win];
            mem_we    <= we[win];
            mem_addr  <= addr[int'(win)*addr_width +: addr_width];
            mem_wdata <= wdata[int'(win)*reg_width +: reg_width];
            state     <= st_access;
          end
        end
        st_access: begin
          mem_we <= 1'b0;
          state  <= st_resp;
        end
        st_resp: begin
          // Memory output reflects the address presented during ACCESS.
          if (!cur_we) begin
            rdata[int'(cur)*reg_width +: reg_width] <= mem_rdata;
          end
          ack   <= grant;
          last  <= cur;
          state <= st_done;
        end
        st_done: begin
          ack   <= '0;
          grant <= '0;
          state <= st_idle;
        end
        default: state <= st_idle;
      endcase
    end
  end

endmodule
